// File: rtl/display_scan_mux.sv
// display_scan_mux: scans DIGITS common-anode 7-seg digits from a double-buffered hex value, with per-slot dead time. Option macro: LEADING_ZERO_BLANK_EN.
// Latency: every output is registered and matches the (idx,cnt) state of its cycle; a load becomes visible at the next frame start.
// Backpressure: none; a newer load before commit replaces the staged value, and only one load_ack is produced per commit.
module display_scan_mux #(
    parameter int DIGITS       = 4,
    parameter int SLOT_CYCLES  = 6,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                on,
    input  logic [4*DIGITS-1:0] number,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                load,
    output logic                load_ack,
    output logic                frame_start,
    output logic [DIGITS-1:0]   AN,
    output logic [7:0]          BCD
);
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt, cnt_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic                run;
    logic                pending;
    logic                commit;
    logic [4*DIGITS-1:0] stage_num, shadow_num, shadow_num_nxt;
    logic [DIGITS-1:0]   stage_dp, shadow_dp, shadow_dp_nxt;
    logic [3:0]          sel_nib;
    logic                sel_dp;
    logic [DIGITS-1:0]   an_dig;
    logic                lz_blank;
    logic                show;
`ifdef LEADING_ZERO_BLANK_EN
    logic                lead;
`endif

    // Active-low segment pattern (g..a) for one hex nibble.
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: seg_of = 7'h40;
            4'h1: seg_of = 7'h79;
            4'h2: seg_of = 7'h24;
            4'h3: seg_of = 7'h30;
            4'h4: seg_of = 7'h19;
            4'h5: seg_of = 7'h12;
            4'h6: seg_of = 7'h02;
            4'h7: seg_of = 7'h78;
            4'h8: seg_of = 7'h00;
            4'h9: seg_of = 7'h10;
            4'hA: seg_of = 7'h08;
            4'hB: seg_of = 7'h03;
            4'hC: seg_of = 7'h46;
            4'hD: seg_of = 7'h21;
            4'hE: seg_of = 7'h06;
            default: seg_of = 7'h0E;
        endcase
    endfunction

    // Next scan position and the shadow value that will be on display after this edge.
    always_comb begin
        commit         = run && (cnt == CNT_LAST) && (idx == IDX_LAST);
        cnt_nxt        = cnt;
        idx_nxt        = idx;
        shadow_num_nxt = shadow_num;
        shadow_dp_nxt  = shadow_dp;
        if (!run) begin
            // First edge out of reset holds slot 0 / cnt 0 so a full frame follows.
            cnt_nxt = '0;
            idx_nxt = '0;
        end else if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
        // A load on the commit cycle itself is the newest value and wins over staging.
        if (commit && load) begin
            shadow_num_nxt = number;
            shadow_dp_nxt  = dp_in;
        end else if (commit && pending) begin
            shadow_num_nxt = stage_num;
            shadow_dp_nxt  = stage_dp;
        end
    end

    // Select nibble, dp and anode for the upcoming slot; optionally flag a leading zero.
    always_comb begin
        sel_nib  = '0;
        sel_dp   = 1'b0;
        an_dig   = '1;
        lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lead     = 1'b1;
`endif
        for (int k = 0; k < DIGITS; k++) begin
`ifdef LEADING_ZERO_BLANK_EN
            // Still "leading" only while every digit so far is 0 with no dp lit.
            lead = lead && (shadow_num_nxt[4*(DIGITS-k)-1 -: 4] == 4'h0)
                        && !shadow_dp_nxt[DIGITS-1-k];
`endif
            if (idx_nxt == IW'(k)) begin
                sel_nib                = shadow_num_nxt[4*(DIGITS-k)-1 -: 4];
                sel_dp                 = shadow_dp_nxt[DIGITS-1-k];
                an_dig[DIGITS-1-k]     = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                lz_blank               = lead && (k != DIGITS - 1);
`endif
            end
        end
        show = on && (int'(cnt_nxt) >= BLANK_CYCLES) && !lz_blank;
    end

    // Scan counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
            run <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
            run <= 1'b1;
        end
    end

    // Staging register, pending flag and frame-aligned shadow copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_num  <= '0;
            stage_dp   <= '0;
            pending    <= 1'b0;
            shadow_num <= '0;
            shadow_dp  <= '0;
        end else begin
            if (load) begin
                stage_num <= number;
                stage_dp  <= dp_in;
            end
            if (commit)
                pending <= 1'b0;
            else if (load)
                pending <= 1'b1;
            shadow_num <= shadow_num_nxt;
            shadow_dp  <= shadow_dp_nxt;
        end
    end

    // Registered pin drivers aligned with the scan position they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            AN          <= '1;
            BCD         <= 8'hFF;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (cnt_nxt == '0) && (idx_nxt == '0);
            load_ack    <= commit && (pending || load);
            if (show) begin
                AN  <= an_dig;
                BCD <= {~sel_dp, seg_of(sel_nib)};
            end else begin
                AN  <= '1;
                BCD <= 8'hFF;
            end
        end
    end
endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: vector table, directed corner sequences and random traffic against a frame-position model.
// Latency: compares every output one half-cycle after each rising edge.
// Backpressure: n/a (bench drives inputs freely).
module tb_display_scan_mux;
    localparam int D     = 4;
    localparam int S     = 6;
    localparam int B     = 1;
    localparam int FRAME = D * S;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        on = 1'b1;
    logic        load = 1'b0;
    logic [15:0] number = '0;
    logic [3:0]  dp_in = '0;
    logic        load_ack, frame_start;
    logic [3:0]  AN;
    logic [7:0]  BCD;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position p counts cycles since the first post-reset cycle (-1 = reset cycle).
    int          p = -1;
    logic [15:0] m_shadow = '0, m_stage = '0;
    logic [3:0]  m_sdp = '0, m_stdp = '0;
    bit          m_pend = 0;
    logic [3:0]  e_an = '1;
    logic [7:0]  e_bcd = 8'hFF;
    logic        e_ack = 1'b0, e_fs = 1'b0;
    logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    typedef struct {
        logic [15:0] num;
        logic [3:0]  dp;
        int          slot;
        int          cnt;
        logic [3:0]  an;
        logic [7:0]  bcd;
    } vec_t;
    vec_t tbl [14];

    display_scan_mux #(.DIGITS(D), .SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .on(on), .number(number), .dp_in(dp_in), .load(load),
        .load_ack(load_ack), .frame_start(frame_start), .AN(AN), .BCD(BCD)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs presented to it.
    task automatic model_edge();
        int slot, c, nib;
        bit commit, lz, dpb;
        if (reset) begin
            p = -1; m_shadow = '0; m_stage = '0; m_sdp = '0; m_stdp = '0; m_pend = 0;
            e_an = '1; e_bcd = 8'hFF; e_ack = 1'b0; e_fs = 1'b0;
            return;
        end
        commit = (p >= 0) && (p % FRAME == FRAME - 1);
        e_ack  = commit && (m_pend || load);
        if (commit) begin
            if (load) begin
                m_shadow = number; m_sdp = dp_in;
            end else if (m_pend) begin
                m_shadow = m_stage; m_sdp = m_stdp;
            end
            m_pend = 0;
        end else if (load) begin
            m_stage = number; m_stdp = dp_in; m_pend = 1;
        end
        p++;
        slot = (p / S) % D;
        c    = p % S;
        e_fs = (p % FRAME == 0);
        nib  = int'((m_shadow >> (4 * (D - 1 - slot))) & 16'h000F);
        dpb  = m_sdp[D-1-slot];
        lz   = 0;
`ifdef LEADING_ZERO_BLANK_EN
        lz = (slot < D - 1) && ((m_shadow >> (4 * (D - 1 - slot))) == 16'h0)
                            && ((m_sdp >> (D - 1 - slot)) == 4'h0);
`endif
        if (!on || c < B || lz) begin
            e_an  = '1;
            e_bcd = 8'hFF;
        end else begin
            e_an  = ~(4'b0001 << (D - 1 - slot));
            e_bcd = {~dpb, seg_tab[nib][6:0]};
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("AN", AN, e_an);
        chk("BCD", BCD, e_bcd);
        chk("load_ack", load_ack, e_ack);
        chk("frame_start", frame_start, e_fs);
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0; on = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic run_to(input int target);
        for (int g = 0; g < 500 && p < target; g++) step();
        if (p != target) begin
            n_cmp++; n_bad++;
            $display("FAIL run_to: position %0d required %0d", p, target);
        end
    endtask

    task automatic load_once(input logic [15:0] v, input logic [3:0] d);
        number = v; dp_in = d; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        int acks, bad, a, b2;
        tbl[0]  = '{16'h1234, 4'h0, 0, 1, 4'b0111, 8'hF9};
        tbl[1]  = '{16'h1234, 4'h0, 1, 3, 4'b1011, 8'hA4};
        tbl[2]  = '{16'h1234, 4'h0, 2, 5, 4'b1101, 8'hB0};
        tbl[3]  = '{16'h1234, 4'h0, 3, 2, 4'b1110, 8'h99};
        tbl[4]  = '{16'h1234, 4'h0, 2, 0, 4'b1111, 8'hFF};
        tbl[5]  = '{16'hABCD, 4'h4, 0, 4, 4'b0111, 8'h88};
        tbl[6]  = '{16'hABCD, 4'h4, 1, 1, 4'b1011, 8'h03};
        tbl[7]  = '{16'hABCD, 4'h4, 2, 2, 4'b1101, 8'hC6};
        tbl[8]  = '{16'hABCD, 4'h4, 3, 5, 4'b1110, 8'hA1};
        tbl[9]  = '{16'h00F0, 4'h0, 2, 1, 4'b1101, 8'h8E};
        tbl[10] = '{16'hF00E, 4'h9, 0, 2, 4'b0111, 8'h0E};
        tbl[11] = '{16'hF00E, 4'h9, 3, 3, 4'b1110, 8'h06};
        tbl[12] = '{16'h5678, 4'h0, 1, 4, 4'b1011, 8'h82};
        tbl[13] = '{16'h9E70, 4'h2, 2, 1, 4'b1101, 8'h78};

        // Table vectors: load mid-frame 0, inspect a slot/cnt of frame 1.
        for (int i = 0; i < 14; i++) begin
            do_reset();
            run_to(3);
            load_once(tbl[i].num, tbl[i].dp);
            run_to(FRAME + tbl[i].slot * S + tbl[i].cnt);
            chk($sformatf("vec%0d_AN", i), AN, tbl[i].an);
            chk($sformatf("vec%0d_BCD", i), BCD, tbl[i].bcd);
        end

        // Two loads in one frame: single ack, intermediate value never shown.
        do_reset();
        run_to(2);
        load_once(16'h1111, 4'h0);
        run_to(7);
        load_once(16'hABCD, 4'b0100);
        acks = 0; bad = 0;
        for (int g = 0; g < 3 * FRAME && p < 3 * FRAME; g++) begin
            step();
            if (load_ack) acks++;
            if (BCD == 8'hF9) bad++;
        end
        chk("two_loads_acks", acks, 1);
        chk("two_loads_no_1111", bad, 0);

        // Load exactly on the commit cycle.
        do_reset();
        run_to(FRAME - 1);
        load_once(16'h00F0, 4'h0);
        chk("commit_load_ack", load_ack, 1);
        chk("commit_load_fs", frame_start, 1);
        run_to(FRAME + 1);
`ifdef LEADING_ZERO_BLANK_EN
        chk("commit_load_slot0", BCD, 8'hFF);
`else
        chk("commit_load_slot0", BCD, 8'hC0);
`endif
        run_to(FRAME + 2 * S + 1);
        chk("commit_load_slot2", BCD, 8'h8E);

        // Display disable mid-slot and resume.
        do_reset();
        load_once(16'h1234, 4'h0);
        run_to(FRAME + 2 * S + 3);
        on = 1'b0;
        step();
        chk("off_AN", AN, 4'b1111);
        chk("off_BCD", BCD, 8'hFF);
        run_to(FRAME + 3 * S + 2);
        on = 1'b1;
        step();
        chk("resume_AN", AN, 4'b1110);
        a = -1; b2 = -1;
        for (int g = 0; g < 80 && b2 < 0; g++) begin
            step();
            if (frame_start) begin
                if (a < 0) a = g; else b2 = g;
            end
        end
        if (b2 < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL fs_period: second frame_start not seen");
        end else chk("fs_period", b2 - a, FRAME);

        // Reset mid-frame with a load pending.
        do_reset();
        run_to(3);
        load_once(16'h1234, 4'h0);
        run_to(2 * S + 1);
        reset = 1'b1;
        step();
        chk("rst_ack", load_ack, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_AN", AN, 4'b1111);
        chk("rst_BCD", BCD, 8'hFF);
        reset = 1'b0;
        step();
        chk("rst_first_fs", frame_start, 1);
        acks = 0; bad = 0;
        for (int g = 0; g < 2 * FRAME; g++) begin
            step();
            if (load_ack) acks++;
            if (BCD != 8'hC0 && BCD != 8'hFF) bad++;
        end
        chk("rst_no_ack", acks, 0);
        chk("rst_shows_zero", bad, 0);

        // Random traffic checked cycle by cycle against the model.
        do_reset();
        for (int g = 0; g < 3000; g++) begin
            reset  = ($urandom_range(0, 299) == 0);
            on     = ($urandom_range(0, 9) != 0);
            load   = ($urandom_range(0, 7) == 0);
            number = 16'($urandom);
            dp_in  = 4'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
